// File: rtl/line_buffer_pkg.sv
// Shared definitions for the 3-row line buffer: parameter defaults and FSM encoding.
package line_buffer_pkg;

    localparam int DEF_WIDTH      = 24;
    localparam int DEF_PIC_WIDTH  = 480;
    localparam int DEF_PIC_HEIGHT = 272;

    // Fill phase of the current frame: rows 0 and 1 only prime the line memories.
    typedef enum logic [1:0] {
        FILL0  = 2'd0,
        FILL1  = 2'd1,
        STREAM = 2'd2
    } lb_state_t;

endpackage

// File: rtl/line_ram.sv
// One line of pixel storage: single clock, synchronous read returning old data,
// independent read and write addresses, one write port.
module line_ram #(
    parameter  int WIDTH = 24,
    parameter  int DEPTH = 480,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,     // active-high synchronous reset of the read register
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write.
    // NOTE: the array itself is never reset; stale contents are masked by the fill phase.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; a same-address write in this cycle is not yet visible (read-old-data).
    // NOTE: non-blocking assignment is what gives read-before-write ordering here.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_buffer_3row.sv
// Three-row sliding window over a raster pixel stream. Each accepted pixel
// produces, one cycle later, the column {line r-2, line r-1, line r} at the
// same horizontal position. lineA holds line r-1, lineB holds line r-2.
//
// lineB is fed from lineA's registered read data, so each lineB write lands
// one accepted pixel later than the lineA write for the same column. That
// write always completes before the same column is read again on the next
// line (PIC_WIDTH >= 2), and it never collides with the current read address.
module line_buffer_3row
    import line_buffer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
    parameter int PIC_HEIGHT = DEF_PIC_HEIGHT
) (
    input  logic             clk,
    input  logic             rst_n,      // synchronous, active-high: 1 = reset
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             line_last
);

    localparam int             CW       = $clog2(PIC_WIDTH);
    localparam int             RW       = $clog2(PIC_HEIGHT);
    localparam logic [CW-1:0]  COL_LAST = CW'(PIC_WIDTH - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(PIC_HEIGHT - 1);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             col_wrap;
    lb_state_t        state, state_nxt;
    logic             stream_pix;
    logic             last_pix;
    logic             pend_valid;
    logic [CW-1:0]    pend_addr;
    logic [WIDTH-1:0] line_a_q;
    logic [WIDTH-1:0] line_b_q;

    assign col_wrap = valid_in && (col == COL_LAST);

    // Column and row position of the next pixel; frozen while valid_in is low.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            col <= col_wrap ? '0 : col + CW'(1);
            if (col_wrap) begin
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= FILL0;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: advance at the end of each line, back to FILL0 after the last row.
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (col_wrap) begin
            unique case (state)
                FILL0:   state_nxt = FILL1;
                FILL1:   state_nxt = STREAM;
                STREAM:  state_nxt = (row == ROW_LAST) ? FILL0 : STREAM;
                default: state_nxt = FILL0;
            endcase
        end
    end

    // FSM outputs: a window column is produced only for pixels accepted while streaming.
    always_comb begin
        stream_pix = valid_in && (state == STREAM);
        last_pix   = stream_pix && (col == COL_LAST);
    end

    // Registered qualifiers and current-line pixel; douts hold through stalls.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_out <= 1'b0;
            line_last <= 1'b0;
            dout3     <= '0;
        end else begin
            valid_out <= stream_pix;
            line_last <= last_pix;
            if (valid_in) begin
                dout3 <= din;
            end
        end
    end

    // Remember where lineA's last read came from so lineB can take that value next pixel.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else if (valid_in) begin
            pend_valid <= 1'b1;
            pend_addr  <= col;
        end
    end

    line_ram #(
        .WIDTH (WIDTH),
        .DEPTH (PIC_WIDTH)
    ) u_line_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (valid_in),
        .rd_addr (col),
        .wr_en   (valid_in),
        .wr_addr (col),
        .wr_data (din),
        .rd_data (line_a_q)
    );

    line_ram #(
        .WIDTH (WIDTH),
        .DEPTH (PIC_WIDTH)
    ) u_line_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (valid_in),
        .rd_addr (col),
        .wr_en   (valid_in && pend_valid),
        .wr_addr (pend_addr),
        .wr_data (line_a_q),
        .rd_data (line_b_q)
    );

    assign dout1 = line_b_q;
    assign dout2 = line_a_q;

endmodule
